// File: rtl/alu_issue_if.sv
// alu_issue_if -- bundle of every handshake and data signal around alu_issue.
//
// Groups:
//   issue side   : in_valid, in_funct, in_rs, in_rt, in_shamt, in_use_imm,
//                  in_imm, in_dst  (to the block), in_ready (from the block)
//   ALU side     : alu_req (from the block), alu_ans (same-cycle answer back)
//   result side  : out_valid, out_result, out_dst, out_wen, out_zero,
//                  out_ovf, out_illegal (from the block), out_ready (to it)
//
// Modports:
//   slave  -- the alu_issue block itself
//   master -- the environment: producer, consumer and external ALU
interface alu_issue_if;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] c;
        logic        over;
        logic        zero;
    } alu_ans_t;

    logic        in_valid;
    logic [5:0]  in_funct;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_shamt;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [4:0]  in_dst;
    logic        in_ready;

    alu_req_t    alu_req;
    alu_ans_t    alu_ans;

    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic        out_zero;
    logic        out_ovf;
    logic        out_illegal;
    logic        out_ready;

    modport slave (
        input  in_valid, in_funct, in_rs, in_rt, in_shamt, in_use_imm, in_imm, in_dst,
        output in_ready,
        output alu_req,
        input  alu_ans,
        output out_valid, out_result, out_dst, out_wen, out_zero, out_ovf, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_funct, in_rs, in_rt, in_shamt, in_use_imm, in_imm, in_dst,
        input  in_ready,
        input  alu_req,
        output alu_ans,
        input  out_valid, out_result, out_dst, out_wen, out_zero, out_ovf, out_illegal,
        output out_ready
    );

endinterface

// File: rtl/alu_issue.sv
// alu_issue -- two-stage issue pipeline in front of an external combinational
// MIPS R-type ALU.
//
// S1 (request stage) decodes the offered funct into an ALU op and operands at
// capture time and drives alu_req straight from its registers.  S2 (result
// stage) captures the ALU's same-cycle answer together with the destination
// and the write-enable decision.  Both stages use a valid/ready handshake;
// an op accepted on edge k is presented on the result side after edge k+1 and
// can be taken on edge k+2.  Throughput is one op per cycle.
//
// Ports:
//   clk    -- rising-edge clock
//   reset  -- synchronous, active-high reset
//   bus    -- alu_issue_if.slave (issue, ALU request/answer, result)
//
// Configuration macro:
//   ALU_OVF_TRAP_EN -- when defined, signed add/sub overflow is reported on
//                      out_ovf and suppresses the register write.  When not
//                      defined, out_ovf is constant 0 and the wrapped result
//                      is written as usual.
module alu_issue (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.slave bus
);

    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLLV = 6'b000100;
    localparam logic [5:0] OP_SRLV = 6'b000110;
    localparam logic [5:0] OP_SRAV = 6'b000111;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;

    // operand-a source selector
    localparam logic [1:0] A_RS    = 2'd0;
    localparam logic [1:0] A_SHAMT = 2'd1;
    localparam logic [1:0] A_RS5   = 2'd2;

    // true for every funct the ALU understands
    function automatic logic fn_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011,
            OP_SLL, OP_SRL, OP_SRA,
            OP_SLLV, OP_SRLV, OP_SRAV: fn_legal = 1'b1;
            default:                   fn_legal = 1'b0;
        endcase
    endfunction

    // variable shifts reuse the immediate-shift ALU ops
    function automatic logic [5:0] fn_map_op(input logic [5:0] f);
        case (f)
            OP_SLLV: fn_map_op = OP_SLL;
            OP_SRLV: fn_map_op = OP_SRL;
            OP_SRAV: fn_map_op = OP_SRA;
            default: fn_map_op = f;
        endcase
    endfunction

    // which field feeds operand a (shift amount for shifts, rs otherwise)
    function automatic logic [1:0] fn_a_sel(input logic [5:0] f);
        case (f)
            OP_SLL, OP_SRL, OP_SRA:    fn_a_sel = A_SHAMT;
            OP_SLLV, OP_SRLV, OP_SRAV: fn_a_sel = A_RS5;
            default:                   fn_a_sel = A_RS;
        endcase
    endfunction

    // S1 registers
    logic        s1_valid_r;
    logic [5:0]  s1_op_r;
    logic [31:0] s1_a_r;
    logic [31:0] s1_b_r;
    logic [4:0]  s1_dst_r;
    logic        s1_illegal_r;

    // S2 registers (drive the result outputs directly)
    logic        out_valid_r;
    logic [31:0] out_result_r;
    logic [4:0]  out_dst_r;
    logic        out_wen_r;
    logic        out_zero_r;
    logic        out_ovf_r;
    logic        out_illegal_r;

    logic        s2_adv_s;
    logic        s1_adv_s;
    logic        in_ready_s;
    logic        accept_s;

    logic        legal_s;
    logic [1:0]  a_sel_s;
    logic [5:0]  op_s;
    logic [31:0] a_s;
    logic [31:0] b_s;

    logic [31:0] res_s;
    logic        zero_s;
    logic        ovf_s;
    logic        wen_s;

    assign s2_adv_s   = !out_valid_r | bus.out_ready;
    assign s1_adv_s   = s1_valid_r & s2_adv_s;
    assign in_ready_s = !s1_valid_r | s2_adv_s;
    assign accept_s   = bus.in_valid & in_ready_s;

    // decode the offered op into ALU op and operands (captured into S1)
    always_comb begin
        legal_s = fn_legal(bus.in_funct);
        a_sel_s = fn_a_sel(bus.in_funct);
        op_s    = 6'b000000;
        a_s     = 32'h0000_0000;
        b_s     = 32'h0000_0000;
        if (legal_s) begin
            op_s = fn_map_op(bus.in_funct);
            case (a_sel_s)
                A_SHAMT: a_s = {27'b0, bus.in_shamt};
                A_RS5:   a_s = {27'b0, bus.in_rs[4:0]};
                default: a_s = bus.in_rs;
            endcase
            // shifts always shift rt, regardless of in_use_imm
            if (a_sel_s != A_RS) begin
                b_s = bus.in_rt;
            end else if (bus.in_use_imm) begin
                b_s = bus.in_imm;
            end else begin
                b_s = bus.in_rt;
            end
        end else begin
            // illegal ops present an all-zero request to the ALU
            op_s = 6'b000000;
            a_s  = 32'h0000_0000;
            b_s  = 32'h0000_0000;
        end
    end

    // S1 request stage: load on accept, empty when it advances, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_op_r      <= 6'b000000;
            s1_a_r       <= 32'h0000_0000;
            s1_b_r       <= 32'h0000_0000;
            s1_dst_r     <= 5'd0;
            s1_illegal_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r   <= 1'b1;
            s1_op_r      <= op_s;
            s1_a_r       <= a_s;
            s1_b_r       <= b_s;
            s1_dst_r     <= bus.in_dst;
            s1_illegal_r <= !legal_s;
        end else if (s1_adv_s) begin
            s1_valid_r   <= 1'b0;
        end else begin
            s1_valid_r   <= s1_valid_r;
        end
    end

    // result, flags and write enable for the op currently in S1
    always_comb begin
        res_s  = 32'h0000_0000;
        zero_s = 1'b0;
        ovf_s  = 1'b0;
        wen_s  = 1'b0;
        if (s1_illegal_r) begin
            res_s  = 32'h0000_0000;
            zero_s = 1'b0;
            ovf_s  = 1'b0;
            wen_s  = 1'b0;
        end else begin
            res_s  = bus.alu_ans.c;
            zero_s = bus.alu_ans.zero;
`ifdef ALU_OVF_TRAP_EN
            ovf_s  = ((s1_op_r == OP_ADD) || (s1_op_r == OP_SUB)) & bus.alu_ans.over;
`else
            ovf_s  = 1'b0;
`endif
            // a trapped overflow must not update the register file
            wen_s  = (s1_dst_r != 5'd0) & !ovf_s;
        end
    end

    // S2 result stage: capture on S1 advance, empty when drained, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= 32'h0000_0000;
            out_dst_r     <= 5'd0;
            out_wen_r     <= 1'b0;
            out_zero_r    <= 1'b0;
            out_ovf_r     <= 1'b0;
            out_illegal_r <= 1'b0;
        end else if (s1_adv_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= res_s;
            out_dst_r     <= s1_dst_r;
            out_wen_r     <= wen_s;
            out_zero_r    <= zero_s;
            out_ovf_r     <= ovf_s;
            out_illegal_r <= s1_illegal_r;
        end else if (s2_adv_s) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.alu_req     = {s1_op_r, s1_a_r, s1_b_r};
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_dst     = out_dst_r;
    assign bus.out_wen     = out_wen_r;
    assign bus.out_zero    = out_zero_r;
    assign bus.out_ovf     = out_ovf_r;
    assign bus.out_illegal = out_illegal_r;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- directed, table-driven bench for alu_issue with a small
// model of the external combinational ALU.  Single ops run from a vector
// table; back-to-back issue, backpressure and mid-flight reset are
// hand-written sequences.
module tb_alu_issue;

`ifdef ALU_OVF_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external combinational ALU
    logic [31:0] m_a, m_b, m_c;
    logic [5:0]  m_op;
    logic        m_over;
    always_comb begin
        m_op   = bus.alu_req.op;
        m_a    = bus.alu_req.a;
        m_b    = bus.alu_req.b;
        m_over = 1'b0;
        case (m_op)
            6'b100000: begin
                m_c    = m_a + m_b;
                m_over = (m_a[31] == m_b[31]) && (m_c[31] != m_a[31]);
            end
            6'b100001: m_c = m_a + m_b;
            6'b100010: begin
                m_c    = m_a - m_b;
                m_over = (m_a[31] != m_b[31]) && (m_c[31] != m_a[31]);
            end
            6'b100011: m_c = m_a - m_b;
            6'b100100: m_c = m_a & m_b;
            6'b100101: m_c = m_a | m_b;
            6'b100110: m_c = m_a ^ m_b;
            6'b100111: m_c = ~(m_a | m_b);
            6'b101010: m_c = {31'b0, $signed(m_a) < $signed(m_b)};
            6'b101011: m_c = {31'b0, m_a < m_b};
            6'b000000: m_c = m_b << m_a[4:0];
            6'b000010: m_c = m_b >> m_a[4:0];
            6'b000011: m_c = $unsigned($signed(m_b) >>> m_a[4:0]);
            default:   m_c = 32'h0000_0000;
        endcase
        bus.alu_ans.c    = m_c;
        bus.alu_ans.over = m_over;
        bus.alu_ans.zero = (m_c == 32'h0000_0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sh, input logic ui, input logic [31:0] imm,
                         input logic [4:0] dst);
        bus.in_valid   = 1'b1;
        bus.in_funct   = f;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_shamt   = sh;
        bus.in_use_imm = ui;
        bus.in_imm     = imm;
        bus.in_dst     = dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  shamt;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [5:0]  e_op;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_res;
        logic        e_wen;
        logic        e_zero;
        logic        e_ovf;
        logic        e_ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved_res;
        logic [4:0]  saved_dst;
        logic [69:0] saved_req;
        int          sent;
        int          got;
        logic        acc;
        logic        tk;

        checks   = 0;
        failures = 0;

        //          funct      rs            rt            sh     ui    imm           dst    op         a             b             result        wen    zero  ovf   ill
        vecs[0]  = '{6'b100000, 32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h0,        5'd3,  6'b100000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, !TRAP, 1'b0, TRAP, 1'b0};
        vecs[1]  = '{6'b000100, 32'h00000023, 32'h00000001, 5'd0,  1'b0, 32'h0,        5'd4,  6'b000000, 32'h00000003, 32'h00000001, 32'h00000008, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{6'b000011, 32'h00000000, 32'h80000000, 5'd4,  1'b0, 32'h0,        5'd6,  6'b000011, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'b001000, 32'h00001234, 32'h00005678, 5'd0,  1'b0, 32'h0,        5'd5,  6'b000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0,  1'b0, 1'b0, 1'b1};
        vecs[4]  = '{6'b100011, 32'h00000005, 32'h00000005, 5'd0,  1'b0, 32'h0,        5'd0,  6'b100011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{6'b100000, 32'h0000000A, 32'h00000063, 5'd0,  1'b1, 32'hFFFFFFFF, 5'd7,  6'b100000, 32'h0000000A, 32'hFFFFFFFF, 32'h00000009, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'b100100, 32'h0000F0F0, 32'h0000FF00, 5'd0,  1'b0, 32'h0,        5'd8,  6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'b100111, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 32'h0,        5'd9,  6'b100111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'b101010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h0,        5'd10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6'b101011, 32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h0,        5'd11, 6'b101011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'b000110, 32'h00000024, 32'h00000080, 5'd0,  1'b1, 32'h00005555, 5'd12, 6'b000010, 32'h00000004, 32'h00000080, 32'h00000008, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{6'b100010, 32'h80000000, 32'h00000001, 5'd0,  1'b0, 32'h0,        5'd13, 6'b100010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, !TRAP, 1'b0, TRAP, 1'b0};
        vecs[12] = '{6'b000000, 32'h0000FFFF, 32'h00000001, 5'd31, 1'b0, 32'h0,        5'd14, 6'b000000, 32'h0000001F, 32'h00000001, 32'h80000000, 1'b1,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{6'b100101, 32'h00000F00, 32'h00000000, 5'd0,  1'b1, 32'h000000F0, 5'd31, 6'b100101, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b1,  1'b0, 1'b0, 1'b0};

        // reset with an op offered: it must not be accepted
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        drive(6'b100001, 32'h11, 32'h22, 5'd0, 1'b0, 32'h0, 5'd1);
        step();
        step();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_alu_req_op", {26'b0, bus.alu_req.op}, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_flags", {27'b0, bus.out_dst, bus.out_wen, bus.out_zero, bus.out_ovf, bus.out_illegal} , 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("post_rst_alu_req_a", bus.alu_req.a, 32'd0);
        chk("post_rst_alu_req_b", bus.alu_req.b, 32'd0);
        step();
        chk("post_rst_no_out", {31'b0, bus.out_valid}, 32'd0);

        // single ops from the table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].funct, vecs[i].rs, vecs[i].rt, vecs[i].shamt,
                  vecs[i].use_imm, vecs[i].imm, vecs[i].dst);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, 32'd1);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_req_op", i), {26'b0, bus.alu_req.op}, {26'b0, vecs[i].e_op});
            chk($sformatf("v%0d_req_a", i), bus.alu_req.a, vecs[i].e_a);
            chk($sformatf("v%0d_req_b", i), bus.alu_req.b, vecs[i].e_b);
            chk($sformatf("v%0d_early_valid", i), {31'b0, bus.out_valid}, 32'd0);
            step();
            chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_result", i), bus.out_result, vecs[i].e_res);
            chk($sformatf("v%0d_dst", i), {27'b0, bus.out_dst}, {27'b0, vecs[i].dst});
            chk($sformatf("v%0d_flags_wen_zero_ovf_ill", i),
                {28'b0, bus.out_wen, bus.out_zero, bus.out_ovf, bus.out_illegal},
                {28'b0, vecs[i].e_wen, vecs[i].e_zero, vecs[i].e_ovf, vecs[i].e_ill});
        end
        step();

        // back-to-back: 4 ops, no bubble, in order
        bus.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin
                drive(6'b100001, j, 32'd100, 5'd0, 1'b0, 32'h0, 5'(j + 1));
                #1;
                chk($sformatf("b2b%0d_in_ready", j), {31'b0, bus.in_ready}, 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (j >= 1 && j <= 4) begin
                chk($sformatf("b2b%0d_out_valid", j), {31'b0, bus.out_valid}, 32'd1);
                chk($sformatf("b2b%0d_result", j), bus.out_result, 32'd100 + 32'(j - 1));
                chk($sformatf("b2b%0d_dst", j), {27'b0, bus.out_dst}, 32'(j));
            end else begin
                chk($sformatf("b2b%0d_out_idle", j), {31'b0, bus.out_valid}, 32'd0);
            end
        end

        // backpressure: 5 stalled cycles, then release
        sent      = 0;
        got       = 0;
        saved_res = 32'h0;
        saved_dst = 5'd0;
        saved_req = 70'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (sent < 3) begin
                drive(6'b100001, 32'h1000 + 32'(sent), 32'h0, 5'd0, 1'b0, 32'h0, 5'(sent + 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                saved_res = bus.out_result;
                saved_dst = bus.out_dst;
                saved_req = bus.alu_req;
            end
            if (cyc == 4) begin
                chk("stall_buffered", 32'(sent), 32'd2);
                chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
                chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("stall_result_stable", bus.out_result, saved_res);
                chk("stall_dst_stable", {27'b0, bus.out_dst}, {27'b0, saved_dst});
                chk("stall_req_stable", bus.alu_req[31:0], saved_req[31:0]);
                chk("stall_req_a_stable", bus.alu_req[63:32], saved_req[63:32]);
            end
            acc = bus.in_valid & bus.in_ready;
            tk  = bus.out_valid & bus.out_ready;
            if (tk) begin
                chk($sformatf("stall_take%0d", got), bus.out_result, 32'h1000 + 32'(got));
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        chk("stall_all_delivered", 32'(got), 32'd3);

        // reset with both stages full
        bus.out_ready = 1'b0;
        drive(6'b100001, 32'h77, 32'h1, 5'd0, 1'b0, 32'h0, 5'd2);
        step();
        drive(6'b100001, 32'h88, 32'h1, 5'd0, 1'b0, 32'h0, 5'd3);
        step();
        drive(6'b100001, 32'h99, 32'h1, 5'd0, 1'b0, 32'h0, 5'd4);
        #1;
        chk("full_before_reset", {30'b0, bus.out_valid, bus.in_ready}, 32'd2);
        reset = 1'b1;
        step();
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("midrst_alu_req", {26'b0, bus.alu_req.op} | bus.alu_req.a | bus.alu_req.b, 32'd0);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("midrst_flushed%0d", k), {31'b0, bus.out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 The inputs SHALL be: in_valid 1 (op offered); in_funct 6 (MIPS R-type funct); in_rs 32; in_rt 32; in_shamt 5; in_use_imm 1; in_imm 32 (pre-extended); in_dst 5.
REQ-003 The output in_ready (1) SHALL mean an offered op is accepted on this edge.
REQ-004 The output alu_req (alu_req_t: op 6, a 32, b 32) SHALL drive the external combinational ALU.
REQ-005 The input alu_ans (alu_ans_t: c 32, over 1, zero 1) SHALL be the same-cycle ALU answer.
REQ-006 The outputs SHALL be: out_valid 1; out_result 32; out_dst 5; out_wen 1; out_zero 1; out_ovf 1; out_illegal 1.
REQ-007 The input out_ready (1) SHALL mean the consumer takes the result on this edge.

Function
REQ-008 Two register stages SHALL be used: S1 (request) and S2 (result), each with its own valid bit.
REQ-009 A transfer SHALL occur on an edge where valid and ready are both high; the producer SHALL hold data stable while valid is high and ready is low.
REQ-010 Advance SHALL be defined as s2_adv = !out_valid | out_ready and s1_adv = s1_valid & s2_adv; in_ready SHALL equal !s1_valid | s2_adv.
REQ-011 Latency SHALL be: an op accepted at edge k gives out_valid high from edge k+2 when there is no backpressure; throughput SHALL be 1 op per cycle.
REQ-012 The funct-to-op mapping SHALL pass through 100000-100111, 101010, 101011, 000000, 000010, 000011 unchanged, and map 000100→000000, 000110→000010, 000111→000011.
REQ-013 Operand a SHALL be zero-extended in_shamt for funct 000000/000010/000011, in_rs[4:0] zero-extended for 000100/000110/000111, and in_rs otherwise.
REQ-014 Operand b SHALL be in_imm when in_use_imm=1, else in_rt; shifts SHALL always use in_rt.
REQ-015 Mapping SHALL be performed at S1 capture; alu_req SHALL be driven directly from S1 registers, with no combinational path from in_* to alu_req.
REQ-016 Any other funct SHALL be illegal: S2 captures out_illegal=1, out_result=0, out_wen=0, out_zero=0, out_ovf=0.
REQ-017 S2 SHALL capture alu_ans.c, alu_ans.zero and S1 dst on s1_adv.
REQ-018 out_wen SHALL be 0 whenever dst=0.
REQ-019 Simultaneous accept and drain SHALL not create a bubble or lose/duplicate an op.
REQ-020 While S1 is stalled, alu_req SHALL remain constant.

Reset
REQ-021 On reset, s1_valid, out_valid, all data registers, alu_req and every output except in_ready SHALL go to 0.
REQ-022 in_ready SHALL be 1 in the cycle after reset.
REQ-023 Reset asserted mid-operation SHALL discard in-flight ops and produce no out_valid for them.
REQ-024 An in_valid asserted during reset SHALL NOT be accepted.

Configuration
REQ-025 With ALU_OVF_TRAP_EN defined, out_ovf SHALL equal alu_ans.over for op 100000/100010, and out_wen SHALL be 0 when out_ovf=1.
REQ-026 Without ALU_OVF_TRAP_EN, out_ovf SHALL be constant 0 and overflow SHALL NOT affect out_wen (wrapped result written).

Verification
REQ-027 add, rs=0x7FFFFFFF, rt=1, dst=3 -> result 0x80000000; with macro: ovf=1, wen=0; without macro: ovf=0, wen=1.
REQ-028 sllv, rs=0x23, rt=1 -> alu_req.op=000000, a=3, result 8; sra, shamt=4, rt=0x80000000 -> result 0xF8000000.
REQ-029 Back-to-back 4 ops, out_ready=1 -> out_valid from edge k+2, one result per cycle, in order.
REQ-030 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 ops buffered, in_ready=0, outputs stable, no loss after release.
REQ-031 funct=001000, dst=5 -> out_illegal=1, result 0, wen=0; subu with dst=0 -> wen=0.
REQ-032 Reset asserted with both stages full -> next cycle out_valid=0, in_ready=1, alu_req=0.
